// File: rtl/dl_session_ctrl.sv
// Download-session controller: stalls the core, drains stores, hands the memory
// write port to the UART downloader, then holds the core in reset for a fixed window.
module dl_session_ctrl #(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int MAX_WORDS    = 4096,
  parameter int IDLE_TIMEOUT = 1048576,
  parameter int RST_CYCLES   = 16,
  localparam int CNT_W       = $clog2(MAX_WORDS) + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              debug_en_i,
  input  logic              cpu_wr_en_i,
  input  logic [ADDR_W-1:0] cpu_wr_addr_i,
  input  logic [DATA_W-1:0] cpu_wr_data_i,
  input  logic              dl_wr_en_i,
  input  logic [ADDR_W-1:0] dl_wr_addr_i,
  input  logic [DATA_W-1:0] dl_wr_data_i,
  output logic              mem_wr_en_o,
  output logic [ADDR_W-1:0] mem_wr_addr_o,
  output logic [DATA_W-1:0] mem_wr_data_o,
  output logic              dl_en_o,
  output logic              cpu_hold_o,
  output logic              cpu_rst_o,
  output logic [CNT_W-1:0]  word_cnt_o,
  output logic              ovf_o,
  output logic              done_o
);

  localparam int IDLE_W = $clog2(IDLE_TIMEOUT + 1);
  localparam int REL_W  = $clog2(RST_CYCLES + 1);
  localparam logic [CNT_W-1:0]  MAX_CNT   = CNT_W'(MAX_WORDS);
  localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(IDLE_TIMEOUT - 1);
  localparam logic [REL_W-1:0]  REL_LAST  = REL_W'(RST_CYCLES - 1);

  typedef enum logic [1:0] {
    S_RUN      = 2'd0,
    S_DRAIN    = 2'd1,
    S_DOWNLOAD = 2'd2,
    S_RELEASE  = 2'd3
  } state_t;

  state_t              state_r;
  logic                en_q_r;
  logic                drain_r;
  logic [IDLE_W-1:0]   idle_r;
  logic [REL_W-1:0]    rel_r;
  logic [CNT_W-1:0]    word_cnt_r;
  logic                ovf_r;
  logic                done_r;
  logic                hold_r;
  logic                dl_en_r;
  logic                cpu_rst_r;
  logic                mem_en_r;
  logic [ADDR_W-1:0]   mem_addr_r;
  logic [DATA_W-1:0]   mem_data_r;

  logic                sel_en_s;
  logic [ADDR_W-1:0]   sel_addr_s;
  logic [DATA_W-1:0]   sel_data_s;
  logic                rise_s;
  logic                room_s;
  logic                dl_exit_s;

  // Write-port source selection and session-control decode for the current state.
  always_comb begin
    sel_en_s   = 1'b0;
    sel_addr_s = cpu_wr_addr_i;
    sel_data_s = cpu_wr_data_i;
    rise_s     = debug_en_i && !en_q_r;
    room_s     = (word_cnt_r < MAX_CNT);
    dl_exit_s  = !debug_en_i ||
                 ((word_cnt_r != {CNT_W{1'b0}}) && (idle_r == IDLE_LAST) && !dl_wr_en_i);
    case (state_r)
      S_RUN, S_DRAIN: begin
        sel_en_s = cpu_wr_en_i;
      end
      S_DOWNLOAD: begin
        sel_en_s   = dl_wr_en_i && room_s;
        sel_addr_s = dl_wr_addr_i;
        sel_data_s = dl_wr_data_i;
      end
      S_RELEASE: begin
        sel_en_s = 1'b0;
      end
      default: begin
        sel_en_s = 1'b0;
      end
    endcase
  end

  // Session FSM; state outputs are loaded together with the next state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= S_RUN;
      en_q_r     <= 1'b0;
      drain_r    <= 1'b0;
      idle_r     <= {IDLE_W{1'b0}};
      rel_r      <= {REL_W{1'b0}};
      word_cnt_r <= {CNT_W{1'b0}};
      ovf_r      <= 1'b0;
      done_r     <= 1'b0;
      hold_r     <= 1'b0;
      dl_en_r    <= 1'b0;
      cpu_rst_r  <= 1'b0;
      mem_en_r   <= 1'b0;
      mem_addr_r <= {ADDR_W{1'b0}};
      mem_data_r <= {DATA_W{1'b0}};
    end else begin
      en_q_r   <= debug_en_i;
      done_r   <= 1'b0;
      mem_en_r <= sel_en_s;
      if (sel_en_s) begin
        mem_addr_r <= sel_addr_s;
        mem_data_r <= sel_data_s;
      end
      case (state_r)
        S_RUN: begin
          if (rise_s) begin
            state_r    <= S_DRAIN;
            hold_r     <= 1'b1;
            drain_r    <= 1'b0;
            word_cnt_r <= {CNT_W{1'b0}};
            ovf_r      <= 1'b0;
            idle_r     <= {IDLE_W{1'b0}};
          end
        end
        S_DRAIN: begin
          if (drain_r) begin
            state_r <= S_DOWNLOAD;
            dl_en_r <= 1'b1;
          end else begin
            drain_r <= 1'b1;
          end
        end
        S_DOWNLOAD: begin
          if (dl_wr_en_i) begin
            idle_r <= {IDLE_W{1'b0}};
            if (room_s) begin
              word_cnt_r <= word_cnt_r + CNT_W'(1);
            end else begin
              ovf_r <= 1'b1;
            end
          end else if ((word_cnt_r != {CNT_W{1'b0}}) && (idle_r != IDLE_LAST)) begin
            idle_r <= idle_r + IDLE_W'(1);
          end
          if (dl_exit_s) begin
            state_r   <= S_RELEASE;
            dl_en_r   <= 1'b0;
            cpu_rst_r <= 1'b1;
            rel_r     <= {REL_W{1'b0}};
          end
        end
        S_RELEASE: begin
          if (rel_r == REL_LAST) begin
            state_r   <= S_RUN;
            hold_r    <= 1'b0;
            cpu_rst_r <= 1'b0;
            done_r    <= 1'b1;
          end else begin
            rel_r <= rel_r + REL_W'(1);
          end
        end
        default: begin
          state_r   <= S_RUN;
          hold_r    <= 1'b0;
          dl_en_r   <= 1'b0;
          cpu_rst_r <= 1'b0;
        end
      endcase
    end
  end

  assign mem_wr_en_o   = mem_en_r;
  assign mem_wr_addr_o = mem_addr_r;
  assign mem_wr_data_o = mem_data_r;
  assign dl_en_o       = dl_en_r;
  assign cpu_hold_o    = hold_r;
  assign cpu_rst_o     = cpu_rst_r;
  assign word_cnt_o    = word_cnt_r;
  assign ovf_o         = ovf_r;
  assign done_o        = done_r;

endmodule
